packet_ingress_arbiter: RTL and testbench

- Shares the single packet_chopper input bus between NUM_SRC upstream packet sources.
- Packet-atomic round-robin: once a source wins, it keeps the bus until its Eop beat is accepted.
- Guards the chopper with a per-packet beat watchdog and flags protocol violations.
- Sits directly in front of packet_chopper; its OutBus_* ports drive the chopper's InBus_* ports.

---
 rtl/packet_ingress_arbiter.sv | 115 +++++++++++
 tb/tb_packet_ingress_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_ingress_arbiter.sv
// packet_ingress_arbiter: packet-atomic round-robin sharing of the packet_chopper input bus,
// with a per-packet beat watchdog that truncates over-long packets and drains their tail.
module packet_ingress_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 256
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic [NUM_SRC-1:0]              S_Val,
    input  logic [NUM_SRC-1:0]              S_Sop,
    input  logic [NUM_SRC-1:0]              S_Eop,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0] S_Mod,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   S_Dat,
    output logic [NUM_SRC-1:0]              S_Rdy,
    output logic                            OutBus_Val,
    output logic                            OutBus_Sop,
    output logic                            OutBus_Eop,
    output logic [DATA_WIDTH/8-1:0]         OutBus_Mod,
    output logic [DATA_WIDTH-1:0]           OutBus_Dat,
    input  logic                            OutBus_Rdy,
    output logic [$clog2(NUM_SRC)-1:0]      Grant,
    output logic                            Busy,
    output logic                            Error
);
    localparam int MW = DATA_WIDTH / 8;
    localparam int GW = $clog2(NUM_SRC);
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   idx;
    logic [CW-1:0]   beat_cnt;
    logic [NUM_SRC-1:0] req;
    logic            found;
    logic            g_val;
    logic            g_sop;
    logic            g_eop;
    logic            in_busy;
    logic            at_limit;

    assign req      = S_Val & S_Sop;
    assign g_val    = S_Val[Grant];
    assign g_sop    = S_Sop[Grant];
    assign g_eop    = S_Eop[Grant];
    assign in_busy  = state == BUSY;
    assign at_limit = beat_cnt == CW'(MAX_BEATS - 1);
    assign Busy     = state != IDLE;

    // Scan downward so the requester closest after last_grant is the one left standing.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = GW'((int'(last_grant) + k) % NUM_SRC);
            if (req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign OutBus_Val = in_busy & g_val;
    assign OutBus_Sop = in_busy & g_sop;
    assign OutBus_Eop = in_busy & (g_eop | at_limit);
    assign OutBus_Mod = in_busy ? S_Mod[Grant*MW +: MW] : '0;
    assign OutBus_Dat = in_busy ? S_Dat[Grant*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_comb begin
        S_Rdy        = '0;
        S_Rdy[Grant] = (in_busy & OutBus_Rdy) | (state == DRAIN);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            Grant      <= '0;
            last_grant <= GW'(NUM_SRC - 1);
            beat_cnt   <= '0;
            Error      <= 1'b0;
        end else begin
            Error <= 1'b0;
            case (state)
                IDLE: begin
                    Error <= |(S_Val & ~S_Sop);
                    if (found) begin
                        Grant <= winner;
                        state <= BUSY;
                    end
                end
                BUSY: if (g_val && OutBus_Rdy) begin
                    beat_cnt <= beat_cnt + CW'(1);
                    Error    <= (g_sop && beat_cnt != '0) || (at_limit && !g_eop);
                    if (g_eop) begin
                        last_grant <= Grant;
                        beat_cnt   <= '0;
                        state      <= IDLE;
                    end else if (at_limit) begin
                        beat_cnt <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: if (g_val && g_eop) begin
                    last_grant <= Grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_ingress_arbiter.sv
// tb_packet_ingress_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a packet-level model of ownership, round-robin order and the beat watchdog.
module tb_packet_ingress_arbiter;
    localparam int NS = 2;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int MB = 8;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [MW-1:0] mod;
        logic [DW-1:0] dat;
    } beat_t;

    logic            Clk = 1'b0;
    logic            Rst = 1'b0;
    logic [NS-1:0]   S_Val = '0;
    logic [NS-1:0]   S_Sop = '0;
    logic [NS-1:0]   S_Eop = '0;
    logic [NS*MW-1:0] S_Mod = '0;
    logic [NS*DW-1:0] S_Dat = '0;
    logic [NS-1:0]   S_Rdy;
    logic            OutBus_Val;
    logic            OutBus_Sop;
    logic            OutBus_Eop;
    logic [MW-1:0]   OutBus_Mod;
    logic [DW-1:0]   OutBus_Dat;
    logic            OutBus_Rdy = 1'b0;
    logic [0:0]      Grant;
    logic            Busy;
    logic            Error;

    packet_ingress_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .Clk(Clk), .Rst(Rst), .S_Val(S_Val), .S_Sop(S_Sop), .S_Eop(S_Eop), .S_Mod(S_Mod),
        .S_Dat(S_Dat), .S_Rdy(S_Rdy), .OutBus_Val(OutBus_Val), .OutBus_Sop(OutBus_Sop),
        .OutBus_Eop(OutBus_Eop), .OutBus_Mod(OutBus_Mod), .OutBus_Dat(OutBus_Dat),
        .OutBus_Rdy(OutBus_Rdy), .Grant(Grant), .Busy(Busy), .Error(Error)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Packet-level model: who owns the bus, how many beats it has used, and whether its tail is dropped.
    int m_own = -1;
    int m_last = NS - 1;
    int m_cnt = 0;
    int m_grant = 0;
    bit m_drop = 0;
    bit m_err = 0;

    // Observations of the DUT, compared against hand-computed literals by the directed tests.
    logic [NS-1:0] acc = '0;
    int fwd = 0, eops = 0, errs = 0, last_mod = 0, idle_run = 0, last_gap = 0;
    int acc_n [NS];
    bit busy_prev = 0, rdy1_seen = 0;
    int glog[$];

    task automatic model_step();
        bit viol = 0;
        int o = m_own;
        logic [NS-1:0] er = '0;
        chk("busy", Busy, 64'(m_own >= 0));
        chk("grant", Grant, 64'(m_grant));
        chk("error", Error, 64'(m_err));
        if (m_own < 0) begin
            chk("idle_val", OutBus_Val, 0);
            chk("idle_rdy", S_Rdy, 0);
            viol = |(S_Val & ~S_Sop);
            for (int k = 1; k <= NS; k++) begin
                int s = (m_last + k) % NS;
                if (S_Val[s] && S_Sop[s]) begin
                    m_own = s;
                    m_grant = s;
                    m_cnt = 0;
                    break;
                end
            end
        end else if (!m_drop) begin
            er[o] = OutBus_Rdy;
            chk("out_val", OutBus_Val, 64'(S_Val[o]));
            chk("out_sop", OutBus_Sop, 64'(S_Sop[o]));
            chk("out_eop", OutBus_Eop, 64'(S_Eop[o] || m_cnt == MB - 1));
            chk("out_mod", OutBus_Mod, S_Mod[o*MW +: MW]);
            chk("out_dat", OutBus_Dat, S_Dat[o*DW +: DW]);
            chk("busy_rdy", S_Rdy, er);
            if (S_Val[o] && OutBus_Rdy) begin
                m_cnt++;
                if (S_Sop[o] && m_cnt > 1) viol = 1;
                if (S_Eop[o]) begin
                    m_last = o;
                    m_own = -1;
                end else if (m_cnt == MB) begin
                    viol = 1;
                    m_drop = 1;
                end
            end
        end else begin
            er[o] = 1'b1;
            chk("drain_val", OutBus_Val, 0);
            chk("drain_rdy", S_Rdy, er);
            if (S_Val[o] && S_Eop[o]) begin
                m_last = o;
                m_own = -1;
                m_drop = 0;
            end
        end
        m_err = viol;
    endtask

    always @(negedge Clk) begin
        acc = S_Val & S_Rdy;
        if (!Rst) begin
            m_own = -1; m_last = NS - 1; m_cnt = 0; m_grant = 0; m_drop = 0; m_err = 0;
            chk("rst_busy", Busy, 0);
            chk("rst_rdy", S_Rdy, 0);
            chk("rst_val", OutBus_Val, 0);
            chk("rst_sop", OutBus_Sop, 0);
            chk("rst_eop", OutBus_Eop, 0);
            chk("rst_grant", Grant, 0);
            chk("rst_error", Error, 0);
        end else begin
            model_step();
            if (OutBus_Val && OutBus_Rdy) begin
                fwd++;
                if (OutBus_Eop) begin
                    eops++;
                    last_mod = int'(OutBus_Mod);
                end
            end
            errs += int'(Error);
            for (int s = 0; s < NS; s++) acc_n[s] += int'(acc[s]);
            rdy1_seen |= S_Rdy[1];
            if (Busy && !busy_prev) begin
                glog.push_back(int'(Grant));
                last_gap = idle_run;
            end
            idle_run = Busy ? 0 : idle_run + 1;
            busy_prev = Busy;
        end
    end

    // Source drivers: each source presents the head of its queue and holds it until accepted.
    beat_t q0[$], q1[$];
    logic [NS-1:0] pres = '0;
    bit gaps = 0;
    int rdy_mode = 0;

    function automatic int qsize(input int s);
        return s == 0 ? q0.size() : q1.size();
    endfunction

    task automatic send(input int s, input int n, input int mod_last, input bit bad_sop);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.sop = (i == 0) || (bad_sop && n > 2 && i == n / 2);
            b.eop = i == n - 1;
            b.mod = (i == n - 1) ? MW'(mod_last) : '0;
            b.dat = {$urandom, $urandom};
            if (s == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        for (int s = 0; s < NS; s++) begin
            beat_t b;
            if (acc[s]) begin
                if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                pres[s] = 1'b0;
            end
            if (!pres[s] && qsize(s) > 0 && (!gaps || $urandom_range(3) != 0)) pres[s] = 1'b1;
            if (pres[s]) begin
                b = (s == 0) ? q0[0] : q1[0];
                S_Val[s] = 1'b1;
                S_Sop[s] = b.sop;
                S_Eop[s] = b.eop;
                S_Mod[s*MW +: MW] = b.mod;
                S_Dat[s*DW +: DW] = b.dat;
            end else begin
                S_Val[s] = 1'b0;
                S_Sop[s] = 1'b0;
                S_Eop[s] = 1'b0;
            end
        end
        OutBus_Rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(3) != 0) : ~OutBus_Rdy;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || pres != '0 || Busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 1);
        tick();
        tick();
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        q0.delete();
        q1.delete();
        pres = '0;
        S_Val = '0;
        S_Sop = '0;
        S_Eop = '0;
        tick();
        tick();
        Rst = 1'b1;
        tick();
    endtask

    initial begin
        int f0, e0, a0, a1;
        for (int s = 0; s < NS; s++) acc_n[s] = 0;
        do_reset();

        // Lone 5-beat packet from source 0.
        f0 = fwd; e0 = errs;
        send(0, 5, 3, 0);
        tick();
        chk("t1_busy_pre", Busy, 0);
        tick();
        chk("t1_busy", Busy, 1);
        chk("t1_grant", Grant, 0);
        drain(100);
        chk("t1_fwd", 64'(fwd - f0), 5);
        chk("t1_mod", 64'(last_mod), 3);
        chk("t1_err", 64'(errs - e0), 0);

        // Simultaneous requests right after reset, then again with last_grant=0.
        do_reset();
        glog.delete();
        send(0, 3, 1, 0);
        send(1, 3, 2, 0);
        drain(100);
        chk("t2_n", 64'(glog.size()), 2);
        chk("t2_first", 64'(glog[0]), 0);
        chk("t2_second", 64'(glog[1]), 1);
        chk("t2_gap", 64'(last_gap), 1);
        send(0, 2, 0, 0);
        drain(100);
        glog.delete();
        send(0, 3, 4, 0);
        send(1, 3, 5, 0);
        drain(100);
        chk("t2r_n", 64'(glog.size()), 2);
        chk("t2r_first", 64'(glog[0]), 1);
        chk("t2r_second", 64'(glog[1]), 0);
        chk("t2r_gap", 64'(last_gap), 1);

        // Back-pressure toggling on a 4-beat packet.
        do_reset();
        f0 = fwd; a0 = acc_n[0]; rdy1_seen = 0;
        rdy_mode = 2;
        send(0, 4, 5, 0);
        drain(100);
        rdy_mode = 0;
        chk("t3_fwd", 64'(fwd - f0), 4);
        chk("t3_acc", 64'(acc_n[0] - a0), 4);
        chk("t3_rdy1", 64'(rdy1_seen), 0);

        // 12-beat packet from source 1 hits the watchdog.
        do_reset();
        f0 = fwd; e0 = errs; a1 = acc_n[1]; eops = 0;
        send(1, 12, 0, 0);
        drain(100);
        chk("t4_fwd", 64'(fwd - f0), 8);
        chk("t4_eops", 64'(eops), 1);
        chk("t4_err", 64'(errs - e0), 1);
        chk("t4_acc", 64'(acc_n[1] - a1), 12);

        // Non-Sop beats in IDLE: three error pulses, nothing consumed, Grant stays at 1.
        f0 = fwd; e0 = errs; a0 = acc_n[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            S_Val[0] = 1'b1;
            S_Sop[0] = 1'b0;
        end
        tick();
        tick();
        tick();
        chk("t5_err", 64'(errs - e0), 3);
        chk("t5_fwd", 64'(fwd - f0), 0);
        chk("t5_acc", 64'(acc_n[0] - a0), 0);
        chk("t5_grant", Grant, 1);

        // Asynchronous reset at beat 3 of a 6-beat packet.
        do_reset();
        f0 = fwd;
        send(0, 6, 0, 0);
        for (int n = 0; n < 50 && fwd - f0 < 2; n++) tick();
        chk("t6_reached", 64'(fwd - f0), 2);
        #1 Rst = 1'b0;
        #1;
        chk("t6_val", OutBus_Val, 0);
        chk("t6_rdy", S_Rdy, 0);
        chk("t6_busy", Busy, 0);
        do_reset();
        glog.delete();
        f0 = fwd;
        send(0, 3, 2, 0);
        drain(100);
        chk("t6_regrant", 64'(glog.size() == 1 && glog[0] == 0), 1);
        chk("t6_fwd", 64'(fwd - f0), 3);

        // Randomized traffic with back-pressure, gaps, long packets and stray Sop beats.
        gaps = 1;
        rdy_mode = 1;
        repeat (600) begin
            if ($urandom_range(4) == 0) begin
                int s = $urandom_range(NS - 1);
                if (qsize(s) < 10) send(s, $urandom_range(1, 12), $urandom_range(MW - 1), $urandom_range(7) == 0);
            end
            tick();
        end
        drain(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
